// File: rtl/mecobo_cmd_sequencer.sv
// mecobo_cmd_sequencer
// Polls the instruction word in the shared RAM. Depending on the opcode it
// streams N configuration words to a pin controller (PROGRAM_PIN) or fetches
// one sample from a pin controller (READ_PIN). It then writes a status word
// back over the instruction, which clears its valid bit. This block is the
// only RAM port-B master on the FPGA side.
//
// Ports:
//   clk, reset         clock and asynchronous active-low reset
//   ram_*              RAM port B; read data is valid one cycle after the address
//   cfg_*              configuration word stream to the pin controllers
//   smp_*              sample request and response from the pin controllers
//   busy               high in every state except IDLE
//   dbg_state          current FSM state, for observation
//
// Handshakes:
//   - A cfg word transfers on a rising edge where cfg_valid and cfg_ready are
//     both high. cfg_pin, cfg_reg and cfg_data stay stable while cfg_valid is
//     high. cfg_ready is ignored while cfg_valid is low.
//   - smp_req is a one-cycle pulse. smp_valid is only honoured in SWAIT, and
//     smp_data is captured on that cycle.
module mecobo_cmd_sequencer #(
  parameter logic [20:0] INSTR_ADDR  = 21'h0000F,
  parameter logic [20:0] RESULT_ADDR = 21'h0000E,
  parameter logic [20:0] DATA_BASE   = 21'h00010,
  parameter int          POLL_GAP    = 4,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic [20:0] ram_addr,
  input  logic [15:0] ram_data_in,
  output logic [15:0] ram_data_out,
  output logic        ram_wr,
  output logic        ram_en,
  output logic [7:0]  cfg_pin,
  output logic [3:0]  cfg_reg,
  output logic [15:0] cfg_data,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic        smp_req,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE, FETCH, CAPTURE, DECODE, DFETCH, DCAPTURE,
    ISSUE, SREQ, SWAIT, WRES, CLEAR
  } state_t;

  localparam logic [7:0]  POLL_LAST   = 8'(POLL_GAP - 1);
  localparam logic [7:0]  TO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [15:0] ST_DONE     = 16'h4000;
  localparam logic [15:0] ST_ILLEGAL  = 16'h6001;
  localparam logic [15:0] ST_TIMEOUT  = 16'h6002;

  state_t      r_state;
  logic [7:0]  r_poll;
  logic [14:0] r_instr;   // valid bit is not kept; it is known to be 1 here
  logic [3:0]  r_k;
  logic [7:0]  r_to;

  logic [2:0]  w_op;
  logic [3:0]  w_n;
  logic [3:0]  w_k_next;

  assign w_op      = r_instr[14:12];
  assign w_n       = r_instr[11:8];
  assign w_k_next  = r_k + 4'd1;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_poll       <= 8'd0;
      r_instr      <= 15'd0;
      r_k          <= 4'd0;
      r_to         <= 8'd0;
      ram_addr     <= 21'd0;
      ram_data_out <= 16'd0;
      ram_wr       <= 1'b0;
      ram_en       <= 1'b0;
      cfg_pin      <= 8'd0;
      cfg_reg      <= 4'd0;
      cfg_data     <= 16'd0;
      cfg_valid    <= 1'b0;
      smp_req      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Outputs are registered: each transition sets up what the next state drives.
      case (r_state)
        IDLE: begin
          if (r_poll == POLL_LAST) begin
            r_poll   <= 8'd0;
            r_state  <= FETCH;
            ram_addr <= INSTR_ADDR;
            ram_en   <= 1'b1;
            ram_wr   <= 1'b0;
            busy     <= 1'b1;
          end else begin
            r_poll <= r_poll + 8'd1;
          end
        end
        FETCH: begin
          ram_en  <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_instr <= ram_data_in[14:0];
          if (ram_data_in[15]) begin
            r_state <= DECODE;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        DECODE: begin
          cfg_pin <= r_instr[7:0];
          if (w_op == 3'd1 && w_n != 4'd0) begin
            r_k      <= 4'd0;
            r_state  <= DFETCH;
            ram_addr <= DATA_BASE;
            ram_en   <= 1'b1;
          end else if (w_op == 3'd2) begin
            r_state <= SREQ;
            smp_req <= 1'b1;
          end else begin
            // NOP, empty PROGRAM_PIN and illegal opcodes all finish here.
            r_state      <= CLEAR;
            ram_addr     <= INSTR_ADDR;
            ram_data_out <= (w_op <= 3'd1) ? ST_DONE : ST_ILLEGAL;
            ram_en       <= 1'b1;
            ram_wr       <= 1'b1;
          end
        end
        DFETCH: begin
          ram_en  <= 1'b0;
          r_state <= DCAPTURE;
        end
        DCAPTURE: begin
          cfg_data  <= ram_data_in;
          cfg_reg   <= r_k;
          cfg_valid <= 1'b1;
          r_state   <= ISSUE;
        end
        ISSUE: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            r_k       <= w_k_next;
            ram_en    <= 1'b1;
            if (w_k_next == w_n) begin
              r_state      <= CLEAR;
              ram_addr     <= INSTR_ADDR;
              ram_data_out <= ST_DONE;
              ram_wr       <= 1'b1;
            end else begin
              r_state  <= DFETCH;
              ram_addr <= DATA_BASE + {17'd0, w_k_next};
            end
          end
        end
        SREQ: begin
          smp_req <= 1'b0;
          r_to    <= 8'd0;
          r_state <= SWAIT;
        end
        SWAIT: begin
          // A sample arriving on the last allowed cycle still wins over the timeout.
          if (smp_valid) begin
            r_state      <= WRES;
            ram_addr     <= RESULT_ADDR;
            ram_data_out <= smp_data;
            ram_en       <= 1'b1;
            ram_wr       <= 1'b1;
          end else if (r_to >= TO_LAST) begin
            r_state      <= CLEAR;
            ram_addr     <= INSTR_ADDR;
            ram_data_out <= ST_TIMEOUT;
            ram_en       <= 1'b1;
            ram_wr       <= 1'b1;
          end else begin
            r_to <= r_to + 8'd1;
          end
        end
        WRES: begin
          r_state      <= CLEAR;
          ram_addr     <= INSTR_ADDR;
          ram_data_out <= ST_DONE;
        end
        CLEAR: begin
          ram_en  <= 1'b0;
          ram_wr  <= 1'b0;
          busy    <= 1'b0;
          r_poll  <= 8'd0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mecobo_cmd_sequencer.md
# mecobo_cmd_sequencer

Multi-cycle command processor between the shared instruction/data RAM and the pin controllers. It polls a fixed instruction word, decodes it, and either streams configuration words to one pin controller or fetches a sample from one. It then writes a result and status back to RAM so the microcontroller sees completion. This block is the only RAM port-B master on the FPGA side.

## Interface
- INSTR_ADDR, 21'h0000F: address of the instruction word
- RESULT_ADDR, 21'h0000E: address where READ_PIN sample is written
- DATA_BASE, 21'h00010: address of first PROGRAM_PIN data word
- POLL_GAP, 4: idle cycles between instruction polls (≥1)
- TIMEOUT, 255: max cycles waiting for smp_valid (8-bit counter)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ram_addr  out  21  RAM address
- ram_data_in  in  16  RAM read data, valid the cycle after address/en
- ram_data_out  out  16  RAM write data
- ram_wr  out  1  write strobe, with ram_en
- ram_en  out  1  RAM access enable
- cfg_pin  out  8  target pin index (config and sample)
- cfg_reg  out  4  config register index within pin controller
- cfg_data  out  16  config word
- cfg_valid  out  1  config word offered
- cfg_ready  in  1  pin controller accepts word
- smp_req  out  1  sample request pulse (1 cycle)
- smp_valid  in  1  sample returned
- smp_data  in  16  sample value
- busy  out  1  high in every state except IDLE

## Operation
- Instruction word: [15] valid, [14:12] opcode, [11:8] word count N, [7:0] pin.
- Opcodes:
  - 0 NOP
  - 1 PROGRAM_PIN
  - 2 READ_PIN
  - others illegal
- States: IDLE, FETCH, CAPTURE, DECODE, DFETCH, DCAPTURE, ISSUE, SREQ, SWAIT, WRES, CLEAR.
- IDLE: count POLL_GAP cycles, then go to FETCH.
- FETCH: ram_addr=INSTR_ADDR, ram_en=1, ram_wr=0, then CAPTURE.
- CAPTURE: latch ram_data_in.
  - Valid=0: go to IDLE.
  - Valid=1: go to DECODE.
- DECODE:
  - NOP: CLEAR with status 16'h4000.
  - PROGRAM_PIN with N=0: CLEAR with 16'h4000.
  - PROGRAM_PIN with N>0: k=0, go to DFETCH.
  - READ_PIN: go to SREQ.
  - Illegal opcode: CLEAR with 16'h6001.
- DFETCH: ram_addr=DATA_BASE+k, read, then DCAPTURE.
- DCAPTURE: latch the word into cfg_data, set cfg_reg=k, then ISSUE.
- ISSUE: cfg_valid=1 and cfg_pin/cfg_reg/cfg_data stay stable until cfg_ready.
  - On cfg_valid&cfg_ready: k++.
  - k==N after increment: go to CLEAR with 16'h4000.
  - Otherwise: go to DFETCH.
- SREQ: smp_req=1 for one cycle, timeout counter cleared, then SWAIT.
- SWAIT:
  - On smp_valid: latch smp_data, go to WRES.
  - Counter reaches TIMEOUT: go to CLEAR with 16'h6002, no result write.
- WRES: write latched sample to RESULT_ADDR (ram_en=ram_wr=1), then CLEAR.
- CLEAR: write the status word to INSTR_ADDR. Status bit 15 is always 0, so the instruction is consumed. Then IDLE.
- Status word: [14] done, [13] error, [1:0] code (01 illegal opcode, 10 timeout).
- Arithmetic and widths:
  - k is 4 bits, N≤15.
  - DATA_BASE+k is 21-bit; wrap-around is impossible for in-range parameters.
  - The timeout counter saturates and is not re-armed within one command.
- Handshake: smp_valid outside SWAIT is ignored; cfg_ready outside ISSUE is ignored.

## Timing
- Reset (asynchronous, reset=0) is legal in any state, including mid-ISSUE. Outputs clear immediately:
  - ram_addr=0, ram_data_out=0, ram_wr=0, ram_en=0
  - cfg_pin=0, cfg_reg=0, cfg_data=0, cfg_valid=0
  - smp_req=0, busy=0
  - state=IDLE, poll counter=0
- After reset release, the first FETCH occurs POLL_GAP cycles later.
- A half-finished command is refetched, because its valid bit was never cleared.
- RAM read: address in cycle t, data captured at the end of cycle t+1.
- ram_en is high only in FETCH, DFETCH, WRES and CLEAR.
- Latencies, from the FETCH cycle to the CLEAR write cycle inclusive:
  - NOP: 4 cycles.
  - PROGRAM_PIN: 4 + N·3 cycles when cfg_ready is held high; each cycle of ready stall adds 1.
  - READ_PIN: 4 + 2 + w cycles, where w is the number of SWAIT cycles up to and including smp_valid.
- smp_valid may arrive in the first SWAIT cycle.
- busy asserts in the FETCH cycle and drops on entry to IDLE.

## Test plan
- Idle poll: RAM[0xF]=0x0000 → read of 0xF every POLL_GAP+2 cycles; no writes; busy low between polls.
- PROGRAM_PIN: RAM[0xF]=0x9305, RAM[0x10..0x12]=A1,B2,C3, cfg_ready=1 → three cfg transfers (pin 5, reg 0/1/2, data A1/B2/C3) → RAM[0xF]=0x4000; then with ready stalled 3 cycles on word 1 → cfg outputs held stable, +3 cycles.
- READ_PIN: RAM[0xF]=0xA00C, smp_valid with 0x1234 after 5 cycles → smp_req one pulse with cfg_pin=12, RAM[0xE]=0x1234, RAM[0xF]=0x4000.
- READ_PIN timeout: smp_valid never → after TIMEOUT cycles RAM[0xF]=0x6002, RAM[0xE] unchanged.
- Illegal opcode 0xF000 → RAM[0xF]=0x6001, no cfg_valid/smp_req; NOP 0x8000 → 0x4000 in 4 cycles.
- Reset asserted mid-ISSUE → outputs 0 immediately; after release the same instruction is re-executed fully.
